// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM state encoding and output mode for the SPI flash responder.
package spi_flash_responder_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_FAST = 8'h0B;
    localparam logic [7:0] CMD_QOUT = 8'h6B;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StIgnore
    } state_e;

    typedef enum logic {
        ModeSingle,
        ModeQuad
    } mode_e;

    function automatic logic [3:0] mode_oe(mode_e mode);
        return (mode == ModeQuad) ? 4'b1111 : 4'b0010;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes CS_N, SCLK and MOSI into the system clock domain and flags SCLK edges and the
// start of a frame.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cs_n_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_low_o,
    output logic cs_fall_o,
    output logic rise_o,
    output logic fall_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;
    logic                   cs_s;
    logic                   sclk_s;

    // CS resets to "selected" so a CS already low at reset release cannot look like a new frame.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q[0]   <= cs_n_i;
            sclk_sync_q[0] <= sclk_i;
            mosi_sync_q[0] <= mosi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync_q[i]   <= cs_sync_q[i-1];
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_low_o  = ~cs_s;
    assign cs_fall_o = cs_prev_q & ~cs_s;
    assign rise_o    = ~cs_s & sclk_s & ~sclk_prev_q;
    assign fall_o    = ~cs_s & ~sclk_s & sclk_prev_q;
    assign mosi_o    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash target: decodes 0x03/0x0B/0x6B reads and streams bytes from a 1-clk-latency memory
// in single-bit or quad-output mode.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 24,
    parameter int unsigned DUMMY_CLKS  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_cs_n,
    input  logic                 spi_sclk,
    input  logic [3:0]           spi_io_in,
    output logic [3:0]           spi_io_out,
    output logic [3:0]           spi_io_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data,
    output logic                 busy,
    output logic                 bad_cmd
);

    logic cs_low, cs_fall, rise, fall, mosi;
    logic unused_io;

    state_e               state_q;
    mode_e                mode_q;
    logic                 dummy_en_q;
    logic [7:0]           cnt_q;
    logic [7:0]           cmd_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [7:0]           shift_q;
    logic [7:0]           next_byte_q;
    logic                 rd_pend_q;
    logic [3:0]           spi_io_out_q;
    logic [3:0]           spi_io_oe_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic                 mem_rd_q;
    logic                 busy_q;
    logic                 bad_cmd_q;

    logic [7:0]           opcode;
    logic [ADDR_BITS-1:0] addr_full;
    logic [7:0]           byte_src;
    logic                 last_unit;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .cs_n_i   (spi_cs_n),
        .sclk_i   (spi_sclk),
        .mosi_i   (spi_io_in[0]),
        .cs_low_o (cs_low),
        .cs_fall_o(cs_fall),
        .rise_o   (rise),
        .fall_o   (fall),
        .mosi_o   (mosi)
    );

    assign unused_io = ^spi_io_in[3:1];
    assign opcode    = {cmd_q[6:0], mosi};
    assign addr_full = {addr_q[ADDR_BITS-2:0], mosi};
    // The first unit of each byte comes from the prefetched byte, the rest from the shifter.
    assign byte_src  = (cnt_q == 8'd0) ? next_byte_q : shift_q;
    assign last_unit = (mode_q == ModeQuad) ? (cnt_q == 8'd1) : (cnt_q == 8'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mode_q       <= ModeSingle;
            dummy_en_q   <= 1'b0;
            cnt_q        <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            shift_q      <= '0;
            next_byte_q  <= '0;
            rd_pend_q    <= 1'b0;
            spi_io_out_q <= '0;
            spi_io_oe_q  <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            bad_cmd_q    <= 1'b0;
        end else begin
            mem_rd_q  <= 1'b0;
            bad_cmd_q <= 1'b0;
            rd_pend_q <= mem_rd_q;
            if (rd_pend_q) begin
                next_byte_q <= mem_data;
            end

            if (state_q != StIdle && !cs_low) begin
                state_q      <= StIdle;
                spi_io_out_q <= '0;
                spi_io_oe_q  <= '0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q <= StCmd;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    StCmd: begin
                        if (rise) begin
                            cmd_q <= opcode;
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'd7) begin
                                cnt_q <= '0;
                                case (opcode)
                                    CMD_READ: begin
                                        state_q    <= StAddr;
                                        mode_q     <= ModeSingle;
                                        dummy_en_q <= 1'b0;
                                    end
                                    CMD_FAST: begin
                                        state_q    <= StAddr;
                                        mode_q     <= ModeSingle;
                                        dummy_en_q <= (DUMMY_CLKS != 0);
                                    end
                                    CMD_QOUT: begin
                                        state_q    <= StAddr;
                                        mode_q     <= ModeQuad;
                                        dummy_en_q <= (DUMMY_CLKS != 0);
                                    end
                                    default: begin
                                        state_q   <= StIgnore;
                                        bad_cmd_q <= 1'b1;
                                        busy_q    <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                    StAddr: begin
                        if (rise) begin
                            addr_q <= addr_full;
                            cnt_q  <= cnt_q + 8'd1;
                            if (cnt_q == 8'(ADDR_BITS - 1)) begin
                                cnt_q      <= '0;
                                mem_addr_q <= addr_full;
                                mem_rd_q   <= 1'b1;
                                state_q    <= dummy_en_q ? StDummy : StData;
                            end
                        end
                    end
                    StDummy: begin
                        if (rise) begin
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'(DUMMY_CLKS - 1)) begin
                                cnt_q   <= '0;
                                state_q <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (fall) begin
                            spi_io_oe_q  <= mode_oe(mode_q);
                            spi_io_out_q <= (mode_q == ModeQuad) ? byte_src[7:4]
                                                                 : {2'b00, byte_src[7], 1'b0};
                            shift_q      <= (mode_q == ModeQuad) ? {byte_src[3:0], 4'h0}
                                                                 : {byte_src[6:0], 1'b0};
                            cnt_q        <= last_unit ? 8'd0 : cnt_q + 8'd1;
                            if (cnt_q == 8'd0) begin
                                mem_addr_q <= mem_addr_q + ADDR_BITS'(1);
                                mem_rd_q   <= 1'b1;
                            end
                        end
                    end
                    StIgnore: begin
                        spi_io_oe_q <= '0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign spi_io_out = spi_io_out_q;
    assign spi_io_oe  = spi_io_oe_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign busy       = busy_q;
    assign bad_cmd    = bad_cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: a bit-banged SPI master with directed and random reads, monitors comparing
// memory reads, returned bytes and output enables against a plain reference model.
module tb_spi_flash_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic [3:0]  spi_io_in = 4'h0;
    logic [3:0]  spi_io_out;
    logic [3:0]  spi_io_oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic        busy;
    logic        bad_cmd;

    int checks = 0;
    int errors = 0;
    int exp_bad = 0;
    int bad_seen = 0;
    int data_mode = 0;
    int mon_bits = 0;
    logic [7:0] mon_byte = 8'h00;
    logic prev_rd = 1'b0;
    logic [23:0] exp_rd[$];
    logic [7:0]  exp_byte[$];

    spi_flash_responder #(
        .ADDR_BITS  (24),
        .DUMMY_CLKS (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_io_in (spi_io_in),
        .spi_io_out(spi_io_out),
        .spi_io_oe (spi_io_oe),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .busy      (busy),
        .bad_cmd   (bad_cmd)
    );

    always #5 clk = ~clk;

    // ROM with one clock of read latency: mem[a] = a[7:0] ^ 0xA5
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[7:0] ^ 8'hA5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                check("mem_rd_gap", 32'(prev_rd), 32'd0);
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_rd: unexpected read at %0h, none expected", mem_addr);
                end else begin
                    check("mem_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
                end
            end
            if (bad_cmd) bad_seen++;
        end
        prev_rd = mem_rd;
    end

    always @(posedge spi_sclk) begin
        if (data_mode == 0) begin
            mon_bits = 0;
            mon_byte = 8'h00;
            if (!spi_cs_n) check("oe_quiet", 32'(spi_io_oe), 32'd0);
        end else begin
            check("oe_data", 32'(spi_io_oe), (data_mode == 2) ? 32'hF : 32'h2);
            if (data_mode == 2) begin
                mon_byte = {mon_byte[3:0], spi_io_out};
                mon_bits += 4;
            end else begin
                mon_byte = {mon_byte[6:0], spi_io_out[1]};
                mon_bits += 1;
            end
            if (mon_bits == 8) begin
                if (exp_byte.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data: unexpected byte %0h, none expected", mon_byte);
                end else begin
                    check("data_byte", 32'(mon_byte), 32'(exp_byte.pop_front()));
                end
                mon_bits = 0;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_io_in[0] = v[i];
            wait_clks(HALF);
            spi_sclk = 1'b1;
            wait_clks(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    // Leaves SCLK high after the last bit so no extra falling edge starts another byte.
    task automatic read_bits(input int n);
        for (int i = 0; i < n; i++) begin
            wait_clks(HALF);
            spi_sclk = 1'b1;
            wait_clks(HALF);
            if (i != n - 1) spi_sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        data_mode = 0;
        spi_cs_n = 1'b1;
        wait_clks(HALF);
        spi_sclk = 1'b0;
        wait_clks(HALF);
        check("busy_idle", 32'(busy), 32'd0);
        check("oe_idle", 32'(spi_io_oe), 32'd0);
        check("bad_cmd_count", 32'(bad_seen), 32'(exp_bad));
    endtask

    task automatic txn(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
        bit ok;
        bit quad;
        int dummy;
        logic [23:0] a;
        ok = (op == 8'h03) || (op == 8'h0B) || (op == 8'h6B);
        quad = (op == 8'h6B);
        dummy = (op == 8'h03) ? 0 : 8;
        if (ok) begin
            for (int i = 0; i <= nbytes; i++) begin
                a = addr + 24'(i);
                exp_rd.push_back(a);
                if (i < nbytes) exp_byte.push_back(a[7:0] ^ 8'hA5);
            end
        end else begin
            exp_bad++;
        end
        spi_cs_n = 1'b0;
        wait_clks(HALF);
        send_bits(32'(op), 8);
        check(ok ? "busy_cmd" : "busy_bad", 32'(busy), ok ? 32'd1 : 32'd0);
        send_bits(32'(addr), 24);
        if (ok) begin
            send_bits(32'd0, dummy);
            data_mode = quad ? 2 : 1;
            read_bits(quad ? 2 * nbytes : 8 * nbytes);
        end
        end_frame();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] op;
        logic [23:0] addr;

        wait_clks(5);
        check("rst_io_out", 32'(spi_io_out), 32'd0);
        check("rst_oe", 32'(spi_io_oe), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bad_cmd", 32'(bad_cmd), 32'd0);
        rst_n = 1'b1;
        wait_clks(10);

        txn(8'h03, 24'h000100, 3);
        txn(8'h6B, 24'h000010, 2);
        txn(8'h03, 24'hFFFFFF, 2);

        // Abort mid-address, then a clean read
        spi_cs_n = 1'b0;
        wait_clks(HALF);
        send_bits(32'h03, 8);
        send_bits(32'h000, 12);
        spi_cs_n = 1'b1;
        wait_clks(3);
        check("abort_busy", 32'(busy), 32'd0);
        end_frame();
        txn(8'h03, 24'h000001, 1);

        txn(8'h9F, 24'h123456, 1);

        // Reset during DATA with CS held low
        exp_rd.push_back(24'h000200);
        exp_rd.push_back(24'h000201);
        spi_cs_n = 1'b0;
        wait_clks(HALF);
        send_bits(32'h03, 8);
        send_bits(32'h000200, 24);
        data_mode = 1;
        read_bits(4);
        data_mode = 0;
        rst_n = 1'b0;
        wait_clks(1);
        check("mid_rst_io_out", 32'(spi_io_out), 32'd0);
        check("mid_rst_oe", 32'(spi_io_oe), 32'd0);
        check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        spi_sclk = 1'b0;
        send_bits(32'h03, 8);
        send_bits(32'h000300, 24);
        read_bits(8);
        check("post_rst_busy", 32'(busy), 32'd0);
        end_frame();
        txn(8'h03, 24'h000005, 2);

        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 3))
                0: op = 8'h03;
                1: op = 8'h0B;
                2: op = 8'h6B;
                default: op = 8'($urandom);
            endcase
            addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) addr = 24'hFFFFFF - 24'($urandom_range(0, 2));
            txn(op, addr, int'($urandom_range(1, 4)));
        end

        wait_clks(20);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("byte_queue_drained", 32'(exp_byte.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI flash responder: the target end of the flash-read interface that tt_um_algofoogle_vga_spi_rom drives as initiator.
- Lets the FPGA build emulate the external flash ROM on spare gpio1 pins, so VGA/SPI bring-up needs no physical chip.
- Oversamples SCLK/CS_N on the system clock, decodes read commands and serves bytes from a synchronous memory port.
- Supports single-bit read and quad-output read.

Parameters:
ADDR_BITS, 24, address width; addresses wrap modulo 2^ADDR_BITS.
DUMMY_CLKS, 8, SCLK cycles between address and data for 0x0B and 0x6B.
SYNC_STAGES, 2, synchronizer depth on spi_cs_n, spi_sclk and spi_io_in.

Ports:
clk  in  1  system clock; must be at least 2*(SYNC_STAGES+3) times the SCLK rate.
rst_n  in  1  synchronous, active-low reset.
spi_cs_n  in  1  chip select from the initiator, active low.
spi_sclk  in  1  SPI clock, mode 0.
spi_io_in  in  4  io[3:0] from the pads; only io[0] (MOSI) is sampled.
spi_io_out  out  4  values driven onto io[3:0].
spi_io_oe  out  4  per-bit output enable; 1 = drive.
mem_addr  out  ADDR_BITS  byte address for the memory read.
mem_rd  out  1  one-clk read strobe.
mem_data  in  8  read data, valid exactly 1 clk after mem_rd.
busy  out  1  high while a transaction is active (CS low and not IGNORE).
bad_cmd  out  1  one-clk pulse when an unsupported opcode is received.

Behaviour:
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop.
  - rise = SCLK 0->1 while CS low; fall = SCLK 1->0 while CS low.
- Reset values: spi_io_out=0, spi_io_oe=0, mem_addr=0, mem_rd=0, busy=0, bad_cmd=0, state=IDLE.
- States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- IDLE -> CMD on synchronized CS falling; clear bit counter.
- CMD: on each rise, shift io[0] in, MSB first. After the 8th bit:
  - 0x03 -> ADDR, mode SINGLE, dummy 0.
  - 0x0B -> ADDR, mode SINGLE, dummy DUMMY_CLKS.
  - 0x6B -> ADDR, mode QUAD, dummy DUMMY_CLKS.
  - any other opcode -> IGNORE, pulse bad_cmd.
- ADDR: shift ADDR_BITS bits on rise, MSB first. On the last bit:
  - assert mem_rd with the assembled address (prefetch).
  - go to DUMMY if dummy count > 0, else DATA.
- DUMMY: count rises. On the last rise go to DATA. Outputs stay tri-stated.
- DATA:
  - Load the shift register from mem_data, then update outputs on each fall.
  - SINGLE: io[1] driven, oe=4'b0010; 8 bits per byte, MSB first.
  - QUAD: io[3:0] driven, oe=4'b1111; 2 nibbles per byte, high nibble first.
  - First data bit/nibble is driven on the fall immediately after the last address/dummy rise.
  - On the first fall of each byte, issue mem_rd for addr+1 and latch the result into a next-byte register.
  - The next byte transfers on the fall after the byte's last bit; there are no gaps.
  - Address increments per byte and wraps at 2^ADDR_BITS.
- IGNORE: oe=0; remains until CS rises.
- CS rise, synchronized, in any state:
  - -> IDLE within SYNC_STAGES+1 clks.
  - oe=0, busy=0; partial byte discarded; no mem_rd issued.
- SCLK edges while CS is high are ignored.
- rst_n low in any state: all outputs return to reset values on the next clk edge. After reset, the FSM needs a fresh CS falling edge; if CS is already low, it waits in IDLE until CS goes high then low.
- busy=1 in CMD/ADDR/DUMMY/DATA.
- mem_rd never asserts on two consecutive clks.

Decomposition:
- Shared package/header: opcode constants (CMD_READ=8'h03, CMD_FAST=8'h0B, CMD_QOUT=8'h6B), state encodings, mode enum (SINGLE/QUAD).
- Sub-module spi_sync_edge: synchronizer plus edge detector for sclk/cs_n, parameterized by SYNC_STAGES, outputs rise/fall/cs_active pulses.
- Memory is external; the bench and the FPGA top bind a ROM with 1-clk read latency.

Test Plan:
1. Read 0x03: CS low, send 0x03, address 0x000100, clock 24 data bits; memory mem[a]=a[7:0]^8'hA5 -> io[1] returns A5,A4,A7; oe=0010 only after the address; mem_addr sequence 0x100,0x101,0x102,0x103.
2. Quad 0x6B: address 0x000010, 8 dummy clocks, 4 data SCLKs -> io[3:0] nibbles B,5,B,4; oe=0 during dummy, 1111 in data.
3. Wrap: 0x03 at address 0xFFFFFF, read 2 bytes -> bytes 5A then A5; mem_addr goes 0xFFFFFF then 0x000000.
4. Abort: raise CS after 12 address bits, then issue a valid 0x03 at 0x000001 -> no mem_rd during the aborted frame, busy drops within 3 clks, second read returns A4.
5. Bad opcode 0x9F -> single bad_cmd pulse, oe stays 0 for the whole frame, busy=0 after the opcode.
6. Reset mid-DATA, rst_n low for 1 clk while CS stays low -> all outputs 0 next clk; no response until CS toggles; the next 0x03 transaction is correct.
